// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, the receive-side partner of the
// button-message transmitter. The rx line is synchronized, a start edge is
// located and every bit is sampled at mid-bit. Each completed byte lands in a
// one-entry valid/ready output register together with its status flags.
//
// Parameters:
//   BAUD_2_CLOCK_RATIO  clocks per bit (>= 4)
//   UART_DATA_BITS      data bits per frame, 5..8, LSB first
//   UART_STOP_BITS      stop bits checked per frame, 1 or 2
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   rx          asynchronous serial line, idles high
//   data        received byte, valid while valid=1
//   valid       output register holds an unconsumed byte
//   ready       consumer accepts data when valid & ready
//   frame_err   a stop bit was sampled low (qualified by valid)
//   parity_err  parity mismatch (qualified by valid), 0 without parity
//   overrun     one-cycle pulse when a completed byte is dropped
//
// Build option: define UART_RX_PARITY_EN to expect one even-parity bit after
// the data bits and report mismatches on parity_err.

module uart_rx #(
  parameter int BAUD_2_CLOCK_RATIO = 1250,
  parameter int UART_DATA_BITS     = 8,
  parameter int UART_STOP_BITS     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      overrun
);

  localparam int CW = $clog2(BAUD_2_CLOCK_RATIO);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_2_CLOCK_RATIO / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_2_CLOCK_RATIO - 1);
  localparam logic [3:0]    DATA_LAST = 4'(UART_DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(UART_STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                    state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [3:0]                bit_cnt, bit_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic                      ferr_acc, ferr_n;
  logic                      complete;
  logic                      load;
  logic                      rx_meta, rx_s, rx_prev;
  logic [1:0]                fill;

  // The synchronizer flops come out of reset holding 1, which is not a real
  // observation of the line. rx_prev stays 0 until the pipeline has been
  // refilled from the pin, so a line held low through reset never looks like
  // a 1->0 start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      fill    <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      fill    <= {fill[0], 1'b1};
      rx_prev <= fill[1] & rx_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      ferr_acc <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      ferr_acc <= ferr_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_acc, perr_n;

  always_ff @(posedge clk) begin
    if (rst) perr_acc <= 1'b0;
    else     perr_acc <= perr_n;
  end
`endif

  // Next-state logic. START waits half a bit to land mid-bit; every later
  // sample is a full bit period after the previous one. The status flags are
  // cleared in IDLE so each frame starts clean.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    bit_n    = bit_cnt;
    shift_n  = shift;
    ferr_n   = ferr_acc;
    complete = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_n   = perr_acc;
`endif
    case (state)
      IDLE: begin
        cnt_n  = '0;
        bit_n  = '0;
        ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n = 1'b0;
`endif
        if (rx_prev && !rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[UART_DATA_BITS-1:1]};
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          perr_n  = rx_s ^ (^shift);
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          bit_n = bit_cnt + 1'b1;
          if (!rx_s) ferr_n = 1'b1;
          if (bit_cnt == STOP_LAST) begin
            bit_n    = '0;
            complete = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A completed byte is accepted if the register is empty or is being
  // drained in this same cycle; otherwise the new byte is dropped.
  assign load = complete && (!valid || ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= complete && !load;
      if (load) begin
        data      <= shift;
        frame_err <= ferr_n;
        valid     <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)       parity_err <= 1'b0;
    else if (load) parity_err <= perr_n;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with R=16, D=8, S=2. Expected
// bytes are queued as frames are sent; accepted bytes are captured at the
// negedge and compared inside each scenario task.

module tb_uart_rx;

  localparam int R = 16;
  localparam int D = 8;
  localparam int S = 2;
  localparam int H = R / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LATENCY = 2 + H + R * (D + P + S) + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, overrun;

  int checks = 0;
  int errors = 0;
  int ovr_count = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  uart_rx #(
    .BAUD_2_CLOCK_RATIO(R),
    .UART_DATA_BITS(D),
    .UART_STOP_BITS(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(data),
    .valid(valid),
    .ready(ready),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Capture every accepted byte and count overrun pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) obs_q.push_back({data, frame_err, parity_err});
      if (overrun) ovr_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(R);
  endtask

  // Start bit, LSB-first data, optional parity bit, first stop 1, second
  // stop as given, then the line returns to idle.
  task automatic send_frame(input logic [7:0] b, input logic s2, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < D; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par) rx = 1'b1;
`endif
    drive_bit(1'b1);
    drive_bit(s2);
    rx = 1'b1;
  endtask

  // Waits for a captured byte and pops it with its expectation.
  task automatic pop_pair(output rec_t o, output rec_t e, output bit got);
    int n;
    n = 0;
    got = 0;
    o = '0;
    e = '0;
    while (n < 20 * R && obs_q.size() == 0) begin
      tick(1);
      n++;
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      got = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b1;
    tick(4);
    checks++;
    if ({valid, data, frame_err, parity_err, overrun} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got valid=%b data=%h fe=%b pe=%b ov=%b want all 0",
               valid, data, frame_err, parity_err, overrun);
    end
    rst = 1'b0;
    tick(6);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_valid got %b want 0", valid);
    end
  endtask

  task automatic test_single_byte;
    rec_t o, e;
    bit got;
    int n;
    bit found;
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    n = 0;
    found = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        while (n < 400 && !found) begin
          tick(1);
          n++;
          if (valid) found = 1;
        end
        checks++;
        if (n != LATENCY) begin
          errors++;
          $display("[TB] FAIL single_latency got %0d cycles want %0d", n, LATENCY);
        end
        tick(1);
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL single_pulse got valid=%b want 0", valid);
        end
      end
    join
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin
      errors++;
      $display("[TB] FAIL single_byte got d=%h fe=%b pe=%b (got=%0d) want d=%h fe=%b pe=%b",
               o.d, o.fe, o.pe, got, e.d, e.fe, e.pe);
    end
  endtask

  task automatic test_glitch;
    rec_t o, e;
    bit got;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * R);
    checks++;
    if (obs_q.size() != 0 || valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_reject got captures=%0d valid=%b want 0 0", obs_q.size(), valid);
    end
    exp_q.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b1, 1'b0);
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin
      errors++;
      $display("[TB] FAIL glitch_next got d=%h fe=%b pe=%b (got=%0d) want d=%h fe=%b pe=%b",
               o.d, o.fe, o.pe, got, e.d, e.fe, e.pe);
    end
  endtask

  task automatic test_framing;
    rec_t o, e;
    bit got;
    exp_q.push_back({8'h5A, 1'b1, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b0);
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin
      errors++;
      $display("[TB] FAIL framing got d=%h fe=%b pe=%b (got=%0d) want d=%h fe=%b pe=%b",
               o.d, o.fe, o.pe, got, e.d, e.fe, e.pe);
    end
    tick(R);
  endtask

  task automatic test_back_to_back;
    rec_t o, e;
    bit got;
    exp_q.push_back({8'h12, 1'b0, 1'b0});
    exp_q.push_back({8'h34, 1'b0, 1'b0});
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      pop_pair(o, e, got);
      checks++;
      if (!got || o !== e) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d] got d=%h fe=%b pe=%b (got=%0d) want d=%h fe=%b pe=%b",
                 k, o.d, o.fe, o.pe, got, e.d, e.fe, e.pe);
      end
    end
  endtask

  task automatic test_overrun;
    rec_t o, e;
    bit got;
    int ov0;
    ready = 1'b0;
    tick(1);
    ov0 = ovr_count;
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b1, 1'b0);
    tick(2);
    checks++;
    if (valid !== 1'b1 || data !== 8'h11) begin
      errors++;
      $display("[TB] FAIL overrun_hold1 got valid=%b data=%h want 1 11", valid, data);
    end
    send_frame(8'h22, 1'b1, 1'b0);
    tick(2);
    checks++;
    if (valid !== 1'b1 || data !== 8'h11) begin
      errors++;
      $display("[TB] FAIL overrun_hold2 got valid=%b data=%h want 1 11", valid, data);
    end
    checks++;
    if (ovr_count - ov0 != 1) begin
      errors++;
      $display("[TB] FAIL overrun_pulses got %0d want 1", ovr_count - ov0);
    end
    ready = 1'b1;
    tick(2);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_drain got valid=%b want 0", valid);
    end
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e || obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL overrun_accept got d=%h (got=%0d extra=%0d) want d=%h extra=0",
               o.d, got, obs_q.size(), e.d);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    rec_t o, e;
    bit got;
    exp_q.push_back({8'h07, 1'b0, 1'b0});
    send_frame(8'h07, 1'b1, 1'b1);
    exp_q.push_back({8'h07, 1'b0, 1'b1});
    send_frame(8'h07, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      pop_pair(o, e, got);
      checks++;
      if (!got || o !== e) begin
        errors++;
        $display("[TB] FAIL parity[%0d] got d=%h fe=%b pe=%b (got=%0d) want d=%h fe=%b pe=%b",
                 k, o.d, o.fe, o.pe, got, e.d, e.fe, e.pe);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    rec_t o, e;
    bit got;
    ready = 1'b1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    tick(R / 2);
    rst = 1'b1;
    tick(2);
    checks++;
    if ({valid, data, frame_err, parity_err, overrun} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs got valid=%b data=%h fe=%b pe=%b ov=%b want all 0",
               valid, data, frame_err, parity_err, overrun);
    end
    rst = 1'b0;
    tick(8 * R);
    checks++;
    if (obs_q.size() != 0 || valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_nobyte got captures=%0d valid=%b want 0 0", obs_q.size(), valid);
    end
    exp_q.push_back({8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b1, 1'b0);
    pop_pair(o, e, got);
    checks++;
    if (!got || o !== e) begin
      errors++;
      $display("[TB] FAIL midreset_next got d=%h fe=%b pe=%b (got=%0d) want d=%h fe=%b pe=%b",
               o.d, o.fe, o.pe, got, e.d, e.fe, e.pe);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    tick(R);
    test_glitch();
    test_framing();
    test_back_to_back();
    tick(R);
    test_overrun();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
